// File: rtl/issue_queue.sv
// ----------------------------------------------------------------------------
// issue_queue : multi-issue reservation station between rename/dispatch and
// the ALU lanes.
//
// It holds up to DEPTH renamed ops. An op wakes up when its used source
// registers are flagged in r_calculated_list. Each cycle the ISSUE_W oldest
// ready ops are presented on the issue lanes; age is the ROB distance from
// rob_head, and lane 0 always carries the oldest. On a checkpoint restore,
// entries outside [rob_head, cp_tail) are squashed in the same cycle.
//
// Optional feature macro: ISSUE_QUEUE_BYPASS_EN
//   defined   : a ready dispatch op may go straight to lane 0 when nothing
//               stored is ready; in that case it is never written.
//   undefined : every op is stored first, so it issues one cycle at the
//               earliest.
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   in_valid/in_ready     dispatch handshake (in_ready = ~full & ~restore)
//   in_<field>            renamed op fields
//   r_calculated_list     per-physical-register value-ready bits
//   restore, cp_tail      checkpoint restore and the restored ROB tail
//   rob_head              current ROB head, used as the age origin
//   out_valid/out_ready   per-lane issue handshake
//   out_<field>           per-lane op fields
//   count, full           occupancy
// ----------------------------------------------------------------------------

`ifndef ROB_LENGTH
`define ROB_LENGTH 16
`endif
`ifndef NUM_D_REG
`define NUM_D_REG 32
`endif
`ifndef NUM_S_REG
`define NUM_S_REG 8
`endif

package nand_cpu_pkg;
    typedef enum logic [2:0] {
        ALU_ADD, ALU_NAND, ALU_SHL, ALU_SHR,
        ALU_MOV, ALU_CMP, ALU_LUI, ALU_NOP
    } AluOp;
endpackage

// One source-operand wakeup check, instantiated once per stored entry.
module iq_wake #(
    parameter int DR_W = 5,
    parameter int NREG = 32
) (
    input  logic            i_vld,
    input  logic            i_use_ra,
    input  logic [DR_W-1:0] i_ra,
    input  logic            i_use_rt,
    input  logic [DR_W-1:0] i_rt,
    input  logic [NREG-1:0] i_calc,
    output logic            o_rdy
);
    assign o_rdy = i_vld & (~i_use_ra | i_calc[i_ra]) & (~i_use_rt | i_calc[i_rt]);
endmodule

module issue_queue #(
    parameter int   DEPTH   = 8,
    parameter int   ISSUE_W = 2,
    localparam int  RA_W    = $clog2(`ROB_LENGTH),
    localparam int  DR_W    = $clog2(`NUM_D_REG),
    localparam int  SR_W    = $clog2(`NUM_S_REG),
    localparam int  CW      = $clog2(DEPTH + 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    // dispatch
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [RA_W-1:0]               in_rob_addr,
    input  nand_cpu_pkg::AluOp            in_alu_op,
    input  logic [5:0]                    in_immdt,
    input  logic                          in_use_ra,
    input  logic                          in_use_rt,
    input  logic [DR_W-1:0]               in_ra_addr,
    input  logic [DR_W-1:0]               in_rt_addr,
    input  logic                          in_write_dst,
    input  logic [DR_W-1:0]               in_rw_addr,
    input  logic [SR_W-1:0]               in_rs_addr,
    // wakeup / recovery
    input  logic [`NUM_D_REG-1:0]         r_calculated_list,
    input  logic                          restore,
    input  logic [RA_W-1:0]               cp_tail,
    input  logic [RA_W-1:0]               rob_head,
    // issue lanes
    output logic [ISSUE_W-1:0]            out_valid,
    input  logic [ISSUE_W-1:0]            out_ready,
    output logic [ISSUE_W-1:0][RA_W-1:0]  out_rob_addr,
    output nand_cpu_pkg::AluOp            out_alu_op [ISSUE_W],
    output logic [ISSUE_W-1:0][5:0]       out_immdt,
    output logic [ISSUE_W-1:0]            out_use_ra,
    output logic [ISSUE_W-1:0]            out_use_rt,
    output logic [ISSUE_W-1:0][DR_W-1:0]  out_ra_addr,
    output logic [ISSUE_W-1:0][DR_W-1:0]  out_rt_addr,
    output logic [ISSUE_W-1:0]            out_write_dst,
    output logic [ISSUE_W-1:0][DR_W-1:0]  out_rw_addr,
    output logic [ISSUE_W-1:0][SR_W-1:0]  out_rs_addr,
    // occupancy
    output logic [CW-1:0]                 count,
    output logic                          full
);
    localparam int IW = $clog2(DEPTH);

    typedef struct packed {
        logic [RA_W-1:0]    rob_addr;
        nand_cpu_pkg::AluOp alu_op;
        logic [5:0]         immdt;
        logic               use_ra;
        logic               use_rt;
        logic [DR_W-1:0]    ra_addr;
        logic [DR_W-1:0]    rt_addr;
        logic               write_dst;
        logic [DR_W-1:0]    rw_addr;
        logic [SR_W-1:0]    rs_addr;
    } iq_ent_t;

    // storage
    iq_ent_t           r_ent [DEPTH];
    logic [DEPTH-1:0]  r_vld;
    logic [CW-1:0]     r_count;

    // combinational
    iq_ent_t              w_in_ent;
    logic [DEPTH-1:0]     w_wake;
    logic [DEPTH-1:0]     w_keep;
    logic [DEPTH-1:0]     w_rdy;
    logic [RA_W-1:0]      w_age   [DEPTH];
    logic [ISSUE_W-1:0]   w_sel_vld;
    logic [IW-1:0]        w_sel_idx [ISSUE_W];
    logic [ISSUE_W-1:0]   w_iss;
    iq_ent_t              w_lane_ent [ISSUE_W];
    logic [IW-1:0]        w_slot;
    logic                 w_slot_ok;
    logic                 w_acc;
    logic                 w_byp;
    logic                 w_wr;
    logic [DEPTH-1:0]     w_vld_nxt;
    logic [CW-1:0]        w_cnt_nxt;

    // [head, tail) on a circular ROB; an empty window when head == tail.
    function automatic logic f_in_range(input logic [RA_W-1:0] a,
                                        input logic [RA_W-1:0] head,
                                        input logic [RA_W-1:0] tail);
        if (tail > head)      return (a >= head) && (a < tail);
        else if (tail < head) return (a >= head) || (a < tail);
        else                  return 1'b0;
    endfunction

    assign w_in_ent = '{rob_addr: in_rob_addr, alu_op: in_alu_op, immdt: in_immdt,
                        use_ra: in_use_ra, use_rt: in_use_rt,
                        ra_addr: in_ra_addr, rt_addr: in_rt_addr,
                        write_dst: in_write_dst, rw_addr: in_rw_addr,
                        rs_addr: in_rs_addr};

    assign full     = (r_count == CW'(DEPTH));
    assign count    = r_count;
    assign in_ready = ~full & ~restore;
    assign w_acc    = in_valid & in_ready;

    // per-entry wakeup, squash gating and age key
    for (genvar g = 0; g < DEPTH; g++) begin : g_ent
        iq_wake #(.DR_W(DR_W), .NREG(`NUM_D_REG)) u_wake (
            .i_vld    (r_vld[g]),
            .i_use_ra (r_ent[g].use_ra),
            .i_ra     (r_ent[g].ra_addr),
            .i_use_rt (r_ent[g].use_rt),
            .i_rt     (r_ent[g].rt_addr),
            .i_calc   (r_calculated_list),
            .o_rdy    (w_wake[g])
        );
        assign w_keep[g] = ~restore | f_in_range(r_ent[g].rob_addr, rob_head, cp_tail);
        assign w_rdy[g]  = w_wake[g] & w_keep[g];
        // ROB_LENGTH is a power of two, so the RA_W-bit wrap is the modulo.
        assign w_age[g]  = r_ent[g].rob_addr - rob_head;
    end

    // Lane k takes the oldest ready entry not already claimed by a lower lane.
    always_comb begin
        logic [DEPTH-1:0] taken;
        logic [RA_W-1:0]  best;
        taken = '0;
        best  = '0;
        for (int k = 0; k < ISSUE_W; k++) begin
            w_sel_vld[k] = 1'b0;
            w_sel_idx[k] = '0;
            best         = '1;
            for (int i = 0; i < DEPTH; i++) begin
                if (w_rdy[i] && !taken[i] && (!w_sel_vld[k] || w_age[i] < best)) begin
                    w_sel_vld[k] = 1'b1;
                    w_sel_idx[k] = IW'(i);
                    best         = w_age[i];
                end
            end
            if (w_sel_vld[k]) taken[w_sel_idx[k]] = 1'b1;
        end
    end

`ifdef ISSUE_QUEUE_BYPASS_EN
    logic w_in_rdy;
    iq_wake #(.DR_W(DR_W), .NREG(`NUM_D_REG)) u_wake_in (
        .i_vld    (1'b1),
        .i_use_ra (in_use_ra),
        .i_ra     (in_ra_addr),
        .i_use_rt (in_use_rt),
        .i_rt     (in_rt_addr),
        .i_calc   (r_calculated_list),
        .o_rdy    (w_in_rdy)
    );
    // Only when no stored op is ready, so lane 0 is otherwise idle.
    assign w_byp = w_acc & w_in_rdy & ~(|w_rdy) & out_ready[0];
`else
    assign w_byp = 1'b0;
`endif

    // lane drive
    always_comb begin
        for (int k = 0; k < ISSUE_W; k++) begin
            w_lane_ent[k] = r_ent[w_sel_idx[k]];
            out_valid[k]  = w_sel_vld[k];
            w_iss[k]      = w_sel_vld[k] & out_ready[k];
        end
        if (w_byp) begin
            w_lane_ent[0] = w_in_ent;
            out_valid[0]  = 1'b1;
        end
    end

    for (genvar k = 0; k < ISSUE_W; k++) begin : g_lane
        assign out_rob_addr[k]  = w_lane_ent[k].rob_addr;
        assign out_alu_op[k]    = w_lane_ent[k].alu_op;
        assign out_immdt[k]     = w_lane_ent[k].immdt;
        assign out_use_ra[k]    = w_lane_ent[k].use_ra;
        assign out_use_rt[k]    = w_lane_ent[k].use_rt;
        assign out_ra_addr[k]   = w_lane_ent[k].ra_addr;
        assign out_rt_addr[k]   = w_lane_ent[k].rt_addr;
        assign out_write_dst[k] = w_lane_ent[k].write_dst;
        assign out_rw_addr[k]   = w_lane_ent[k].rw_addr;
        assign out_rs_addr[k]   = w_lane_ent[k].rs_addr;
    end

    // Dispatch slot comes from the start-of-cycle valid vector, so a slot
    // freed by issue this cycle is not reused until the next one.
    always_comb begin
        w_slot    = '0;
        w_slot_ok = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!r_vld[i]) begin
                w_slot    = IW'(i);
                w_slot_ok = 1'b1;
            end
        end
    end

    assign w_wr = w_acc & ~w_byp & w_slot_ok;

    // Next valid vector; count is its popcount, which keeps it exact when
    // dispatch, issue and squash all land in one cycle.
    always_comb begin
        w_vld_nxt = r_vld & w_keep;
        for (int k = 0; k < ISSUE_W; k++)
            if (w_iss[k]) w_vld_nxt[w_sel_idx[k]] = 1'b0;
        if (w_wr) w_vld_nxt[w_slot] = 1'b1;
        w_cnt_nxt = '0;
        for (int i = 0; i < DEPTH; i++)
            w_cnt_nxt = w_cnt_nxt + CW'(w_vld_nxt[i]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld   <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) r_ent[i] <= '0;
        end else begin
            r_vld   <= w_vld_nxt;
            r_count <= w_cnt_nxt;
            if (w_wr) r_ent[w_slot] <= w_in_ent;
        end
    end

endmodule

// File: tb/tb_issue_queue.sv
`ifndef ROB_LENGTH
`define ROB_LENGTH 16
`endif
`ifndef NUM_D_REG
`define NUM_D_REG 32
`endif
`ifndef NUM_S_REG
`define NUM_S_REG 8
`endif

module tb_issue_queue;
    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 in_valid;
    logic                 in_ready;
    logic [3:0]           in_rob_addr;
    nand_cpu_pkg::AluOp   in_alu_op;
    logic [5:0]           in_immdt;
    logic                 in_use_ra, in_use_rt;
    logic [4:0]           in_ra_addr, in_rt_addr;
    logic                 in_write_dst;
    logic [4:0]           in_rw_addr;
    logic [2:0]           in_rs_addr;
    logic [31:0]          calc;
    logic                 restore;
    logic [3:0]           cp_tail, rob_head;
    logic [1:0]           out_valid, out_ready;
    logic [1:0][3:0]      out_rob_addr;
    nand_cpu_pkg::AluOp   out_alu_op [2];
    logic [1:0][5:0]      out_immdt;
    logic [1:0]           out_use_ra, out_use_rt;
    logic [1:0][4:0]      out_ra_addr, out_rt_addr;
    logic [1:0]           out_write_dst;
    logic [1:0][4:0]      out_rw_addr;
    logic [1:0][2:0]      out_rs_addr;
    logic [3:0]           count;
    logic                 full;

    int n_tests = 0;
    int n_fail  = 0;

    issue_queue #(.DEPTH(8), .ISSUE_W(2)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rob_addr(in_rob_addr), .in_alu_op(in_alu_op), .in_immdt(in_immdt),
        .in_use_ra(in_use_ra), .in_use_rt(in_use_rt),
        .in_ra_addr(in_ra_addr), .in_rt_addr(in_rt_addr),
        .in_write_dst(in_write_dst), .in_rw_addr(in_rw_addr), .in_rs_addr(in_rs_addr),
        .r_calculated_list(calc), .restore(restore), .cp_tail(cp_tail), .rob_head(rob_head),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_rob_addr(out_rob_addr), .out_alu_op(out_alu_op), .out_immdt(out_immdt),
        .out_use_ra(out_use_ra), .out_use_rt(out_use_rt),
        .out_ra_addr(out_ra_addr), .out_rt_addr(out_rt_addr),
        .out_write_dst(out_write_dst), .out_rw_addr(out_rw_addr), .out_rs_addr(out_rs_addr),
        .count(count), .full(full)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0; in_rob_addr = '0; in_alu_op = nand_cpu_pkg::ALU_ADD;
        in_immdt = 6'd9; in_use_ra = 1'b0; in_use_rt = 1'b0;
        in_ra_addr = '0; in_rt_addr = '0; in_write_dst = 1'b1;
        in_rw_addr = 5'd3; in_rs_addr = 3'd1;
        calc = '1; restore = 1'b0; cp_tail = '0; rob_head = '0; out_ready = '0;
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic disp(input logic [3:0] rob, input logic ura, input logic [4:0] ra);
        in_rob_addr = rob; in_use_ra = ura; in_ra_addr = ra; in_use_rt = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        // 1: reset state, fill to full, drain two per cycle oldest first
        do_reset();
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_count", 32'(count), 32'h0);
        chk("rst_full", 32'(full), 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'h1);
        for (int i = 0; i < 8; i++) disp(4'(i), 1'b0, 5'd0);
        #1;
        chk("fill_count", 32'(count), 32'h8);
        chk("fill_full", 32'(full), 32'h1);
        chk("fill_in_ready", 32'(in_ready), 32'h0);
        out_ready = 2'b11;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk("drain_valid", 32'(out_valid), 32'h3);
            chk("drain_lane0", 32'(out_rob_addr[0]), 32'(2 * c));
            chk("drain_lane1", 32'(out_rob_addr[1]), 32'(2 * c + 1));
            tick();
        end
        #1;
        chk("drain_count", 32'(count), 32'h0);

        // 2: age wraps around the ROB; dispatch order differs from age order
        do_reset();
        rob_head = 4'd14;
        disp(4'd1, 1'b0, 5'd0);
        disp(4'd0, 1'b0, 5'd0);
        disp(4'd15, 1'b0, 5'd0);
        out_ready = 2'b11;
        #1;
        chk("wrap_lane0", 32'(out_rob_addr[0]), 32'd15);
        chk("wrap_lane1", 32'(out_rob_addr[1]), 32'd0);
        tick();
        chk("wrap_next_valid", 32'(out_valid), 32'h1);
        chk("wrap_next_lane0", 32'(out_rob_addr[0]), 32'd1);

        // 3: same-cycle wakeup
        do_reset();
        calc = 32'hFFFF_FFDF;
        disp(4'd0, 1'b1, 5'd5);
        #1;
        chk("wait_valid", 32'(out_valid), 32'h0);
        calc = '1;
        #1;
        chk("wake_valid0", 32'(out_valid[0]), 32'h1);

        // 4: restore squashes out-of-range entries and blocks dispatch
        do_reset();
        rob_head = 4'd3;
        disp(4'd2, 1'b0, 5'd0);
        disp(4'd4, 1'b0, 5'd0);
        disp(4'd7, 1'b0, 5'd0);
        restore = 1'b1; cp_tail = 4'd6;
        in_rob_addr = 4'd5; in_valid = 1'b1;
        #1;
        chk("rest_in_ready", 32'(in_ready), 32'h0);
        chk("rest_valid", 32'(out_valid), 32'h1);
        chk("rest_lane0", 32'(out_rob_addr[0]), 32'd4);
        tick();
        in_valid = 1'b0; restore = 1'b0;
        #1;
        chk("rest_count", 32'(count), 32'h1);
        chk("rest_after_valid", 32'(out_valid), 32'h1);
        chk("rest_after_lane0", 32'(out_rob_addr[0]), 32'd4);

        // 5: partial acceptance, retained op moves to lane 0
        do_reset();
        disp(4'd0, 1'b0, 5'd0);
        disp(4'd1, 1'b0, 5'd0);
        out_ready = 2'b01;
        #1;
        chk("part_valid", 32'(out_valid), 32'h3);
        chk("part_lane0", 32'(out_rob_addr[0]), 32'd0);
        chk("part_lane1", 32'(out_rob_addr[1]), 32'd1);
        tick();
        chk("part_count", 32'(count), 32'h1);
        chk("part_next_valid", 32'(out_valid), 32'h1);
        chk("part_next_lane0", 32'(out_rob_addr[0]), 32'd1);

        // asynchronous reset mid-operation
        rst = 1'b1;
        #1;
        chk("async_count", 32'(count), 32'h0);
        chk("async_valid", 32'(out_valid), 32'h0);
        tick();
        rst = 1'b0;

        // 6: dispatch-to-issue latency, with and without bypass
        do_reset();
        out_ready = 2'b01;
        in_rob_addr = 4'd3; in_use_ra = 1'b0; in_use_rt = 1'b0; in_valid = 1'b1;
        #1;
`ifdef ISSUE_QUEUE_BYPASS_EN
        chk("byp_valid", 32'(out_valid), 32'h1);
        chk("byp_lane0", 32'(out_rob_addr[0]), 32'd3);
`else
        chk("nobyp_valid", 32'(out_valid), 32'h0);
`endif
        tick();
        in_valid = 1'b0;
        #1;
`ifdef ISSUE_QUEUE_BYPASS_EN
        chk("byp_count", 32'(count), 32'h0);
        chk("byp_after_valid", 32'(out_valid), 32'h0);
`else
        chk("nobyp_count", 32'(count), 32'h1);
        chk("nobyp_valid_t1", 32'(out_valid), 32'h1);
        chk("nobyp_lane0", 32'(out_rob_addr[0]), 32'd3);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
